// File: rtl/mem_fetch_unit.sv
// mem_fetch_unit: single-outstanding CPU memory access unit driving the W_* strobe bus,
// with bus timeout/abort. Define FETCH_LAST_READ_BUF_EN to add a one-entry last-read buffer.

module mem_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        W_RST,
  input  logic        f_enable,
  input  logic        f_write_enable,
  input  logic [31:0] addr,
  input  logic [31:0] f_data_i,
  input  logic [1:0]  thread,
  output logic [31:0] f_data_o,
  output logic        f_ack,
  output logic        f_err,
  input  logic        W_ACK,
  input  logic [31:0] W_DATA_I,
  output logic        W_STB,
  output logic        W_WRITE,
  output logic [31:0] W_ADDR,
  output logic [31:0] W_DATA_O,
  output logic [1:0]  W_TID
);

  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    tid_q, tid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

`ifdef FETCH_LAST_READ_BUF_EN
  logic          buf_valid_q, buf_valid_d;
  logic [31:0]   buf_tag_q, buf_tag_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          buf_hit;

  assign buf_hit = buf_valid_q && !f_write_enable && (addr == buf_tag_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tid_d   = tid_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef FETCH_LAST_READ_BUF_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (f_enable) begin
`ifdef FETCH_LAST_READ_BUF_EN
          if (buf_hit) begin
            // Buffered read: answer directly, bus registers stay untouched
            rdata_d = buf_data_q;
            ack_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            addr_d  = addr;
            write_d = f_write_enable;
            wdata_d = f_data_i;
            tid_d   = thread;
            stb_d   = 1'b1;
            state_d = S_BUS;
          end
`else
          addr_d  = addr;
          write_d = f_write_enable;
          wdata_d = f_data_i;
          tid_d   = thread;
          stb_d   = 1'b1;
          state_d = S_BUS;
`endif
        end
      end

      S_BUS: begin
        cnt_d = cnt_q + CW'(1);
        // W_ACK is checked first so an ack on the last allowed cycle still succeeds
        if (W_ACK) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = S_RESP;
          if (!write_q) begin
            rdata_d = W_DATA_I;
          end
`ifdef FETCH_LAST_READ_BUF_EN
          if (!write_q) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = addr_q;
            buf_data_d  = W_DATA_I;
          end else if (buf_valid_q && (addr_q == buf_tag_q)) begin
            buf_data_d  = wdata_q;
          end
`endif
        end else if (cnt_q == CNT_LAST) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = S_RESP;
          if (!write_q) begin
            rdata_d = ERR_DATA;
          end
`ifdef FETCH_LAST_READ_BUF_EN
          if (addr_q == buf_tag_q) begin
            buf_valid_d = 1'b0;
          end
`endif
        end
      end

      S_RESP: begin
        state_d = S_HOLD;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge W_RST) begin
    if (W_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tid_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tid_q   <= tid_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef FETCH_LAST_READ_BUF_EN
  always_ff @(posedge clk or posedge W_RST) begin
    if (W_RST) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end
`endif

  assign f_data_o = rdata_q;
  assign f_ack    = ack_q;
  assign f_err    = err_q;
  assign W_STB    = stb_q;
  assign W_WRITE  = write_q;
  assign W_ADDR   = addr_q;
  assign W_DATA_O = wdata_q;
  assign W_TID    = tid_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Scoreboard bench for mem_fetch_unit: stimulus pushes expected bus transfers and responses,
// a bus-slave monitor and a response monitor pop and compare them.

module tb_mem_fetch_unit;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        W_RST;
  logic        f_enable, f_write_enable;
  logic [31:0] addr, f_data_i;
  logic [1:0]  thread;
  logic [31:0] f_data_o;
  logic        f_ack, f_err;
  logic        slave_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] W_DATA_I = '0;
  logic        W_STB, W_WRITE;
  logic [31:0] W_ADDR, W_DATA_O;
  logic [1:0]  W_TID;

  mem_fetch_unit #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .W_RST(W_RST),
    .f_enable(f_enable), .f_write_enable(f_write_enable),
    .addr(addr), .f_data_i(f_data_i), .thread(thread),
    .f_data_o(f_data_o), .f_ack(f_ack), .f_err(f_err),
    .W_ACK(slave_ack | stray_ack), .W_DATA_I(W_DATA_I),
    .W_STB(W_STB), .W_WRITE(W_WRITE), .W_ADDR(W_ADDR),
    .W_DATA_O(W_DATA_O), .W_TID(W_TID)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned at;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  tid;
    int unsigned len;
  } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  int errors = 0;
  int checks = 0;
  logic [31:0] model_data = '0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (!W_RST) begin
      if (f_ack) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got f_ack=1 data=%0h expected no response (cycle %0d)", f_data_o, cyc);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_data", 64'(f_data_o), 64'(e.data));
          check("rsp_err", 64'(f_err), 64'(e.err));
          check("rsp_cycle", 64'(cyc), 64'(e.at));
        end
      end else begin
        check("err_without_ack", 64'(f_err), 64'(0));
      end
    end
  end

  // Bus slave and bus monitor
  int unsigned ack_delay = 0;
  logic [31:0] ack_data  = '0;
  int unsigned stb_cnt   = 0;
  logic        stb_prev  = 1'b0;
  logic        cur_ok    = 1'b0;
  bus_t        cur;

  always @(negedge clk) begin
    slave_ack = 1'b0;
    if (W_STB) begin
      stb_cnt++;
      if (stb_cnt == 1) begin
        if (bus_q.size() == 0) begin
          checks++; errors++; cur_ok = 1'b0;
          $display("FAIL unexpected_stb: got W_STB=1 addr=%0h expected no transfer (cycle %0d)", W_ADDR, cyc);
        end else begin
          cur = bus_q.pop_front();
          cur_ok = 1'b1;
        end
      end
      if (cur_ok) begin
        check("bus_addr", 64'(W_ADDR), 64'(cur.addr));
        check("bus_write", 64'(W_WRITE), 64'(cur.wr));
        check("bus_tid", 64'(W_TID), 64'(cur.tid));
        if (cur.wr) check("bus_wdata", 64'(W_DATA_O), 64'(cur.wdata));
      end
      if (ack_delay != 0 && stb_cnt == ack_delay) begin
        slave_ack = 1'b1;
        W_DATA_I  = ack_data;
      end else begin
        W_DATA_I  = 32'hBAD0_0000 + stb_cnt;
      end
    end else begin
      if (stb_prev && cur_ok && cur.len != 0) check("stb_len", 64'(stb_cnt), 64'(cur.len));
      stb_cnt  = 0;
      W_DATA_I = 32'h0BAD_F00D;
    end
    stb_prev = W_STB;
  end

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (rsp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    if (rsp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL ack_wait: got no f_ack within 200 cycles expected %0d pending responses", rsp_q.size());
      rsp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Issue one request from IDLE; delay=0 means the slave never acks.
  task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] t,
                     input int unsigned delay, input logic [31:0] rdat, input logic hit);
    int unsigned c, len;
    logic        tmo;
    rsp_t        r;
    bus_t        b;
    c   = cyc;
    tmo = (delay == 0) || (delay > TO);
    len = tmo ? TO : delay;
    f_enable = 1'b1; f_write_enable = wr; addr = a; f_data_i = d; thread = t;
    ack_delay = delay; ack_data = rdat;
    if (hit) begin
      model_data = rdat;
      r.err = 1'b0;
      r.at  = c + 1;
    end else begin
      b.addr = a; b.wr = wr; b.wdata = d; b.tid = t; b.len = len;
      bus_q.push_back(b);
      if (!wr) model_data = tmo ? 32'hDEADBEEF : rdat;
      r.err = tmo;
      r.at  = c + 1 + len;
    end
    r.data = model_data;
    rsp_q.push_back(r);
    @(negedge clk);
    f_enable = 1'b0; addr = 32'hFFFF_FFF0; f_data_i = 32'h5555_5555; thread = 2'd3;
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

  initial begin
    rsp_t r;
    bus_t b;
    W_RST = 1'b1;
    f_enable = 1'b0; f_write_enable = 1'b0; addr = '0; f_data_i = '0; thread = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'({W_STB, W_WRITE, W_TID, f_ack, f_err}), 64'(0));
    check("reset_addr", 64'(W_ADDR), 64'(0));
    check("reset_wdata", 64'(W_DATA_O), 64'(0));
    check("reset_rdata", 64'(f_data_o), 64'(0));
    W_RST = 1'b0;
    @(negedge clk);

    // Basic read, write, timeout, ack on the last allowed cycle, write timeout
    req(1'b0, 32'h10, 32'h0, 2'd0, 1, 32'h12345678, 1'b0);
    req(1'b1, 32'h20, 32'hA5A5A5A5, 2'd2, 3, 32'h0BADBAD0, 1'b0);
    req(1'b0, 32'h40, 32'h0, 2'd1, 0, 32'h0, 1'b0);
    req(1'b0, 32'h44, 32'h0, 2'd3, TO, 32'hCAFEF00D, 1'b0);
    req(1'b1, 32'h48, 32'h11112222, 2'd1, 0, 32'h0, 1'b0);

    // W_ACK while idle must not produce a response
    stray_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_ack_no_resp", 64'(f_ack), 64'(0));
    end
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Back-to-back with f_enable held high; address changes after the first ack
    f_enable = 1'b1; f_write_enable = 1'b0; addr = 32'h4; thread = 2'd0;
    ack_delay = 2; ack_data = 32'h44444444;
    b.addr = 32'h4; b.wr = 1'b0; b.wdata = '0; b.tid = 2'd0; b.len = 2;
    bus_q.push_back(b);
    r.data = 32'h44444444; r.err = 1'b0; r.at = cyc + 3;
    rsp_q.push_back(r);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (f_ack) break;
    end
    if (!f_ack) begin
      checks++; errors++;
      $display("FAIL b2b_first_ack: got no f_ack expected one within 50 cycles");
    end
    addr = 32'h5; ack_data = 32'h55555555;
    b.addr = 32'h5;
    bus_q.push_back(b);
    r.data = 32'h55555555; r.at = cyc + 5;
    rsp_q.push_back(r);
    model_data = 32'h55555555;
    repeat (3) @(negedge clk);
    f_enable = 1'b0;
    wait_drain();

    // Asynchronous reset in the middle of a bus transfer
    f_enable = 1'b1; f_write_enable = 1'b0; addr = 32'h60; thread = 2'd2; ack_delay = 0;
    b.addr = 32'h60; b.wr = 1'b0; b.wdata = '0; b.tid = 2'd2; b.len = 0;
    bus_q.push_back(b);
    @(negedge clk);
    f_enable = 1'b0;
    @(negedge clk);
    #2 W_RST = 1'b1;
    #1;
    check("rst_stb_drop", 64'(W_STB), 64'(0));
    check("rst_addr_clear", 64'(W_ADDR), 64'(0));
    check("rst_no_ack", 64'(f_ack), 64'(0));
    @(negedge clk);
    W_RST = 1'b0;
    model_data = '0;
    repeat (6) @(negedge clk);
    check("rst_bus_consumed", 64'(bus_q.size()), 64'(0));
    req(1'b0, 32'h70, 32'h0, 2'd1, 1, 32'h70707070, 1'b0);

`ifdef FETCH_LAST_READ_BUF_EN
    req(1'b0, 32'h30, 32'h0, 2'd0, 2, 32'h30303030, 1'b0);
    req(1'b0, 32'h30, 32'h0, 2'd0, 1, 32'h30303030, 1'b1);
    req(1'b1, 32'h30, 32'h31313131, 2'd0, 1, 32'h0, 1'b0);
    req(1'b0, 32'h30, 32'h0, 2'd0, 1, 32'h31313131, 1'b1);
    req(1'b1, 32'h30, 32'h32323232, 2'd0, 0, 32'h0, 1'b0);
    req(1'b0, 32'h30, 32'h0, 2'd0, 1, 32'h33333333, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("bus_q_empty", 64'(bus_q.size()), 64'(0));
    check("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
